last_round: RTL and testbench
=============================

# last_round

Final-round datapath of the AES-128 core. In encrypt mode it applies SubBytes, ShiftRows and AddRoundKey to a 128-bit state, with no MixColumns. In decrypt mode it applies InvShiftRows, InvSubBytes and AddRoundKey. It sits after the round-1..9 pipeline and takes the round-10 subkey (encrypt) or the round-0 key (decrypt) from the key expansion. The result is registered, one cycle after the inputs are sampled.

## Interface
- No parameters; width is fixed at 128 bits (AES-128 state).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  qualifies encrypt/keyword/input_data this cycle
- encrypt  in  1  1 = forward last round, 0 = inverse last round
- keyword  in  128  round subkey XORed in by AddRoundKey
- input_data  in  128  state entering the round
- result  out  128  registered round output
- out_valid  out  1  result holds a newly computed value

## Operation
- State layout is column-major, byte k = input_data[127-8k -: 8], s[r][c] = byte 4c+r.
  - Row r = bytes r, r+4, r+8, r+12.
- Encrypt (encrypt=1), result = ShiftRows(SubBytes(input_data)) ^ keyword.
  - SubBytes: FIPS-197 S-box applied to each of the 16 bytes.
  - ShiftRows: row r rotated left by r byte positions, s'[r][c] = s[r][(c+r) mod 4].
- Decrypt (encrypt=0), result = InvSubBytes(InvShiftRows(input_data)) ^ keyword.
  - InvShiftRows: s'[r][c] = s[r][(c-r) mod 4].
  - InvSubBytes: FIPS-197 inverse S-box on each byte.
- SubBytes and ShiftRows commute, so either order is acceptable inside each path.
- AddRoundKey is a plain 128-bit XOR with no byte reordering of keyword.
- All arithmetic is bytewise lookup, permutation and XOR. No carries, no width growth.

## Timing
- Single-cycle registered datapath; the S-box logic is fully combinational.
- Latency: 1 clock, throughput 1 block/clock.
- On a rising edge with reset=1:
  - result <= 0 and out_valid <= 0.
  - reset dominates in_valid in the same cycle.
- On a rising edge with reset=0 and in_valid=1:
  - result <= f(encrypt, keyword, input_data) and out_valid <= 1.
  - encrypt is sampled on this same edge.
- On a rising edge with reset=0 and in_valid=0: result holds its previous value and out_valid <= 0.
- Inputs may change every cycle, including toggling encrypt between back-to-back blocks. Each block uses its own sampled mode.
- Reset asserted while a block is in flight: that block is discarded and no out_valid pulse appears for it.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry SBOX and INV_SBOX byte constant arrays;
  - the state typedef (16 x 8-bit, byte 0 = MSB);
  - shift_rows and inv_shift_rows functions.
- One sub-module, aes_sbox_byte: 8-bit in, encrypt select, 8-bit out. Instantiate it 16 times.
- The top-level module holds the permutation, the XOR and the output registers.

## Test plan
- Encrypt, FIPS-197 C.1 round 10, in_valid=1:
  - stimulus: input_data=bd6e7c3df2b5779e0b61216e8b10b689, keyword=13111d7fe3944a17f307a78b4d2b30c5;
  - one cycle later: result=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid=1.
- Decrypt, FIPS-197 C.1 inverse last round:
  - stimulus: input_data=6353e08c0960e104cd70b751bacad0e7, keyword=000102030405060708090a0b0c0d0e0f;
  - one cycle later: result=00112233445566778899aabbccddeeff.
- Encrypt with input_data=0 and keyword=0 -> result=63636363636363636363636363636363. Decrypt with input_data=63636363636363636363636363636363 and keyword=0 -> result=0.
- Back-to-back blocks:
  - stimulus: the encrypt and decrypt vectors above on consecutive cycles;
  - required: the correct results on consecutive cycles, with out_valid high for both.
- Hold behaviour: after a valid block, drop in_valid and change the inputs -> result unchanged, out_valid=0.
- Reset behaviour: assert reset together with in_valid=1 -> next cycle result=0, out_valid=0. Deassert reset -> normal operation resumes on the next valid input.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the last-round datapath.
//   SBOX / INV_SBOX : FIPS-197 forward and inverse byte substitution tables
//   aes_state_t     : 16 x 8-bit state, byte 0 is the most significant byte,
//                     byte 4c+r holds state element s[r][c]
//   shift_rows      : s'[r][c] = s[r][(c+r) mod 4]
//   inv_shift_rows  : s'[r][c] = s[r][(c-r) mod 4]
// -----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [0:15][7:0] aes_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Row r of the state is bytes r, r+4, r+8, r+12; each row is rotated
    // left by r positions.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4*c + r] = s[4*((c + r) % 4) + r];
            end
        end
        return o;
    endfunction

    // Inverse rotation: row r rotated right by r positions.  (c - r) mod 4 is
    // formed as (c + 4 - r) mod 4 to keep the operand non-negative.
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4*c + r] = s[4*((c + 4 - r) % 4) + r];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// -----------------------------------------------------------------------------
// aes_sbox_byte
// Combinational byte substitution, forward or inverse.
//   i_data    : byte to substitute
//   i_encrypt : 1 = forward S-box, 0 = inverse S-box
//   o_data    : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic       i_encrypt,
    output logic [7:0] o_data
);

    assign o_data = i_encrypt ? SBOX[i_data] : INV_SBOX[i_data];

endmodule

// File: rtl/last_round.sv
// -----------------------------------------------------------------------------
// last_round
// Final AES-128 round, registered output, latency 1, throughput 1 block/clk.
//   encrypt=1 : result = ShiftRows(SubBytes(input_data)) ^ keyword
//   encrypt=0 : result = InvSubBytes(InvShiftRows(input_data)) ^ keyword
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-high reset, clears result and out_valid
//   in_valid   : qualifies encrypt / keyword / input_data this cycle
//   encrypt    : mode select for this block
//   keyword    : round subkey for AddRoundKey
//   input_data : state entering the round
//   result     : registered round output, held while no new block arrives
//   out_valid  : one-cycle pulse per newly computed result
// -----------------------------------------------------------------------------
module last_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         encrypt,
    input  logic [127:0] keyword,
    input  logic [127:0] input_data,
    output logic [127:0] result,
    output logic         out_valid
);

    aes_state_t w_state_p0;
    aes_state_t w_perm_p0;
    aes_state_t w_sub_p0;

    logic [127:0] r_result_p1;
    logic         r_vld_p1;

    assign w_state_p0 = input_data;

    // Byte substitution and row rotation commute, so the permutation is
    // applied first in both modes and a single bank of 16 S-boxes follows it.
    assign w_perm_p0 = encrypt ? shift_rows(w_state_p0) : inv_shift_rows(w_state_p0);

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        aes_sbox_byte u_sbox (
            .i_data    (w_perm_p0[gi]),
            .i_encrypt (encrypt),
            .o_data    (w_sub_p0[gi])
        );
    end

    // ---- stage p0 -> p1: AddRoundKey and output register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result_p1 <= '0;
            r_vld_p1    <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_result_p1 <= w_sub_p0 ^ keyword;
            end
        end
    end

    assign result    = r_result_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_last_round.sv
module tb_last_round;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         encrypt;
    logic [127:0] keyword;
    logic [127:0] input_data;
    logic [127:0] result;
    logic         out_valid;

    int n_vec;
    int n_err;

    logic [127:0] sb_q[$];

    logic [7:0] m_sbox [256];
    logic [7:0] m_inv  [256];

    last_round dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .encrypt    (encrypt),
        .keyword    (keyword),
        .input_data (input_data),
        .result     (result),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // GF(2^8) arithmetic, independent of any lookup table.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        if (v == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gf_mul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic enc, input logic [127:0] key,
                                           input logic [127:0] din);
        logic [127:0] o;
        int src;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                if (enc) begin
                    src = 4*((col + row) % 4) + row;
                    o[127-8*(4*col+row) -: 8] = m_sbox[din[127-8*src -: 8]];
                end else begin
                    src = 4*((col + 3*row) % 4) + row;
                    o[127-8*(4*col+row) -: 8] = m_inv[din[127-8*src -: 8]];
                end
            end
        end
        return o ^ key;
    endfunction

    // Drive one block on the current (negative) edge; queue its expected result.
    task automatic send(input logic enc, input logic [127:0] key, input logic [127:0] din,
                        input logic [127:0] exp);
        in_valid   = 1'b1;
        encrypt    = enc;
        keyword    = key;
        input_data = din;
        if (!reset) sb_q.push_back(exp);
    endtask

    task automatic send_rand(input logic enc);
        logic [127:0] k;
        logic [127:0] d;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(enc, k, d, model(enc, k, d));
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) check_vec("spurious_valid", 128'(out_valid), 128'd0);
            else                  check_vec("sb_result", result, sb_q.pop_front());
        end
    end

    localparam logic [127:0] ENC_IN  = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] ENC_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] ENC_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DEC_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] DEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DEC_OUT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ALL63   = 128'h63636363636363636363636363636363;

    initial begin
        logic [127:0] hold_exp;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) m_sbox[i] = sbox_calc(8'(i));
        for (int i = 0; i < 256; i++) m_inv[m_sbox[i]] = 8'(i);

        reset = 1'b1; in_valid = 1'b0; encrypt = 1'b0; keyword = '0; input_data = '0;
        repeat (2) @(negedge clk);
        check_vec("reset_result", result, 128'd0);
        check_vec("reset_valid", 128'(out_valid), 128'd0);

        // Model sanity against the standard vectors.
        check_vec("model_enc", model(1'b1, ENC_KEY, ENC_IN), ENC_OUT);
        check_vec("model_dec", model(1'b0, DEC_KEY, DEC_IN), DEC_OUT);

        reset = 1'b0;
        // Known-answer vectors back to back, with mode toggling.
        send(1'b1, ENC_KEY, ENC_IN, ENC_OUT); @(negedge clk);
        send(1'b0, DEC_KEY, DEC_IN, DEC_OUT); @(negedge clk);
        check_vec("b2b_valid", 128'(out_valid), 128'd1);
        send(1'b1, '0, '0, ALL63);            @(negedge clk);
        check_vec("b2b_valid2", 128'(out_valid), 128'd1);
        send(1'b0, '0, ALL63, '0);            @(negedge clk);

        // Random blocks, mode toggling each cycle or randomly.
        for (int i = 0; i < 24; i++) begin
            send_rand(i < 8 ? i[0] : 1'($urandom_range(0, 1)));
            @(negedge clk);
        end

        // Hold: valid block then idle cycles with changing inputs.
        send(1'b1, ENC_KEY, DEC_IN, model(1'b1, ENC_KEY, DEC_IN));
        hold_exp = model(1'b1, ENC_KEY, DEC_IN);
        @(negedge clk);
        in_valid = 1'b0; encrypt = 1'b0; keyword = ~ENC_KEY; input_data = ENC_IN;
        @(negedge clk);
        check_vec("hold_result", result, hold_exp);
        check_vec("hold_valid", 128'(out_valid), 128'd0);
        input_data = ALL63;
        @(negedge clk);
        check_vec("hold_result2", result, hold_exp);

        // Reset together with a valid block: the block is dropped.
        reset = 1'b1;
        send(1'b1, ENC_KEY, ENC_IN, ENC_OUT);
        @(negedge clk);
        check_vec("rst_vld_result", result, 128'd0);
        check_vec("rst_vld_valid", 128'(out_valid), 128'd0);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_vec("post_rst_idle", 128'(out_valid), 128'd0);
        send(1'b0, DEC_KEY, DEC_IN, DEC_OUT);
        @(negedge clk);
        check_vec("resume_valid", 128'(out_valid), 128'd1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
